// File: rtl/cylon_pkg.sv
// rtl/cylon_pkg.sv - shared states, legal eye patterns and bounce step rule for cylon_checker
package cylon_pkg;

  typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

  localparam logic [3:0] PAT_EYE0 = 4'b0001;
  localparam logic [3:0] PAT_EYE1 = 4'b0010;
  localparam logic [3:0] PAT_EYE2 = 4'b0100;
  localparam logic [3:0] PAT_EYE3 = 4'b1000;

  typedef struct packed {
    logic [1:0] idx;
    logic       dir;
  } step_t;

  // The eye bounces off both ends, so the ends force the direction.
  function automatic step_t next_step(input logic [1:0] pos, input logic dir);
    step_t s;
    if (pos == 2'd3) begin
      s.idx = 2'd2;
      s.dir = 1'b0;
    end else if (pos == 2'd0) begin
      s.idx = 2'd1;
      s.dir = 1'b1;
    end else if (dir) begin
      s.idx = pos + 2'd1;
      s.dir = 1'b1;
    end else begin
      s.idx = pos - 2'd1;
      s.dir = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/cylon_checker_onehot4_dec.sv
// rtl/cylon_checker_onehot4_dec.sv - combinational one-hot detect and index of a 4-bit LED pattern
module onehot4_dec
  import cylon_pkg::*;
(
  input  logic [3:0] i_din,
  output logic [1:0] o_idx,
  output logic       o_onehot
);

  always_comb begin
    o_idx    = 2'd0;
    o_onehot = 1'b1;
    case (i_din)
      PAT_EYE0: o_idx = 2'd0;
      PAT_EYE1: o_idx = 2'd1;
      PAT_EYE2: o_idx = 2'd2;
      PAT_EYE3: o_idx = 2'd3;
      default:  o_onehot = 1'b0;
    endcase
  end

endmodule

// File: rtl/cylon_checker.sv
// rtl/cylon_checker.sv - cylon LED sequence monitor; stall timer enabled by CYLON_CHECK_STALL_EN
module cylon_checker
  import cylon_pkg::*;
#(
  parameter int MXPRE    = 21,
  parameter int LOCK_CNT = 3,
  parameter int ERRW     = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [3:0]      din,
  input  logic            err_clr,
  output logic [1:0]      pos,
  output logic            dir,
  output logic            locked,
  output logic            err_pulse,
  output logic [ERRW-1:0] err_cnt,
  output logic            stall
);

  logic [3:0]      r_din_r, r_din_p;
  state_t          r_state;
  logic [1:0]      r_pos;
  logic            r_dir, r_locked, r_err_pulse;
  logic [3:0]      r_goodcnt;
  logic [ERRW-1:0] r_err_cnt;
  logic [1:0]      w_idx;
  logic            w_onehot, w_change, w_adj, w_timeout;
  logic [3:0]      w_gc_next;
  step_t           w_step;

  onehot4_dec u_dec (
    .i_din    (r_din_r),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  assign w_change  = (r_din_r != r_din_p);
  assign w_step    = next_step(r_pos, r_dir);
  assign w_gc_next = r_goodcnt + 4'd1;
  // Explicit end guards keep the 2-bit +/-1 from wrapping 3<->0.
  assign w_adj     = w_onehot && (((r_pos != 2'd3) && (w_idx == r_pos + 2'd1)) ||
                                  ((r_pos != 2'd0) && (w_idx == r_pos - 2'd1)));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_din_r     <= 4'd0;
      r_din_p     <= 4'd0;
      r_state     <= HUNT;
      r_pos       <= 2'd0;
      r_dir       <= 1'b0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_goodcnt   <= 4'd0;
    end else begin
      r_din_r     <= din;
      r_din_p     <= r_din_r;
      r_err_pulse <= 1'b0;
      if (w_timeout) begin
        r_state  <= HUNT;
        r_locked <= 1'b0;
      end else if (w_change) begin
        case (r_state)
          HUNT: if (w_onehot) begin
            r_pos     <= w_idx;
            r_goodcnt <= 4'd0;
            r_state   <= SYNC;
          end
          SYNC: if (w_adj) begin
            r_dir     <= (w_idx > r_pos);
            r_pos     <= w_idx;
            r_goodcnt <= w_gc_next;
            if (w_gc_next == 4'(LOCK_CNT)) begin
              r_state  <= LOCK;
              r_locked <= 1'b1;
            end
          end else if (w_onehot) begin
            r_pos     <= w_idx;
            r_goodcnt <= 4'd0;
          end else begin
            r_state <= HUNT;
          end
          LOCK: if (w_onehot && (w_idx == w_step.idx)) begin
            r_pos <= w_idx;
            r_dir <= w_step.dir;
          end else begin
            r_err_pulse <= 1'b1;
            r_locked    <= 1'b0;
            if (w_onehot) begin
              r_pos     <= w_idx;
              r_goodcnt <= 4'd0;
              r_state   <= SYNC;
            end else begin
              r_state <= HUNT;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  // Counts the registered pulse, so a clear coinciding with it keeps that error.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= r_err_pulse ? ERRW'(1) : '0;
    end else if (r_err_pulse && (r_err_cnt != {ERRW{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERRW'(1);
    end
  end

`ifdef CYLON_CHECK_STALL_EN
  localparam int TW = MXPRE + 2;
  localparam logic [TW-1:0] TMAX  = '1;
  localparam logic [TW-1:0] TNEAR = TMAX - TW'(1);
  logic [TW-1:0] r_timer;
  logic          r_stall;

  assign w_timeout = !w_change && (r_timer == TNEAR);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_timer <= '0;
      r_stall <= 1'b0;
    end else if (w_change) begin
      r_timer <= '0;
      r_stall <= 1'b0;
    end else begin
      if (r_timer != TMAX) r_timer <= r_timer + TW'(1);
      if (w_timeout) r_stall <= 1'b1;
    end
  end

  assign stall = r_stall;
`else
  assign w_timeout = 1'b0;
  assign stall     = 1'b0;
`endif

  assign pos       = r_pos;
  assign dir       = r_dir;
  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_cylon_checker.sv
// tb/tb_cylon_checker.sv - scoreboard bench for cylon_checker (MXPRE=2, LOCK_CNT=3, ERRW=8)
module tb_cylon_checker;

`ifdef CYLON_CHECK_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n, err_clr;
  logic [3:0] din;
  logic [1:0] pos;
  logic       dir, locked, err_pulse, stall;
  logic [7:0] err_cnt;

  typedef struct {
    int         cyc;
    int         tag;
    logic [1:0] pos;
    logic       dir;
    logic       lk;
    logic       ep;
    logic [7:0] cnt;
    logic       st;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_ep = 0;
  int   tag = 0;
  logic prev_ep = 1'b0;

  logic [3:0] sw_p   [9] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd1, 4'd2};
  logic [1:0] sw_pos [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1};
  logic       sw_dir [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       sw_lk  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  cylon_checker #(.MXPRE(2), .LOCK_CNT(3), .ERRW(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .din       (din),
    .err_clr   (err_clr),
    .pos       (pos),
    .dir       (dir),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .stall     (stall)
  );

  always #5 clock = ~clock;

  always begin
    @(posedge clock);
    #1;
    cyc = cyc + 1;
    if (err_pulse === 1'b1) begin
      n_ep = n_ep + 1;
      n_checks = n_checks + 1;
      if (prev_ep === 1'b1) begin
        n_fail = n_fail + 1;
        $display("FAIL err_pulse_width cyc=%0d got two consecutive high cycles, need one", cyc);
      end
    end
    prev_ep = err_pulse;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_checks = n_checks + 1;
      if (e.cyc != cyc) begin
        n_fail = n_fail + 1;
        $display("FAIL chk%0d missed at cyc=%0d, scheduled for cyc=%0d", e.tag, cyc, e.cyc);
      end else if ({pos, dir, locked, err_pulse, err_cnt, stall} !==
                   {e.pos, e.dir, e.lk, e.ep, e.cnt, e.st}) begin
        n_fail = n_fail + 1;
        $display("FAIL chk%0d cyc=%0d got pos=%0d dir=%b lk=%b ep=%b cnt=%0d st=%b need pos=%0d dir=%b lk=%b ep=%b cnt=%0d st=%b",
                 e.tag, cyc, pos, dir, locked, err_pulse, err_cnt, stall,
                 e.pos, e.dir, e.lk, e.ep, e.cnt, e.st);
      end
    end
  end

  task automatic ex(input int at, input logic [1:0] p, input logic d, input logic lk,
                    input logic ep, input logic [7:0] c, input logic st);
    exp_t e;
    tag = tag + 1;
    e = '{cyc: at, tag: tag, pos: p, dir: d, lk: lk, ep: ep, cnt: c, st: st};
    q.push_back(e);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int t0;
    reset_n = 1'b0;
    din     = 4'd0;
    err_clr = 1'b0;
    @(negedge clock);
    ex(cyc + 1, 2'd0, 0, 0, 0, 8'd0, 0);
    hold(2);
    reset_n = 1'b1;
    hold(1);

    for (int i = 0; i < 9; i++) begin
      din = sw_p[i];
      if (i == 3) ex(cyc + 1, 2'd2, 1, 0, 0, 8'd0, 0);
      ex(cyc + 2, sw_pos[i], sw_dir[i], sw_lk[i], 0, 8'd0, 0);
      hold(4);
    end

    din = 4'd8;
    ex(cyc + 2, 2'd3, 1, 0, 1, 8'd0, 0);
    ex(cyc + 3, 2'd3, 1, 0, 0, 8'd1, 0);
    hold(4);
    din = 4'd4; ex(cyc + 2, 2'd2, 0, 0, 0, 8'd1, 0); hold(4);
    din = 4'd2; ex(cyc + 2, 2'd1, 0, 0, 0, 8'd1, 0); hold(4);
    din = 4'd1; ex(cyc + 2, 2'd0, 0, 1, 0, 8'd1, 0); hold(4);
    din = 4'd2; ex(cyc + 2, 2'd1, 1, 1, 0, 8'd1, 0); hold(4);

    din = 4'b0110;
    ex(cyc + 2, 2'd1, 1, 0, 1, 8'd1, 0);
    ex(cyc + 3, 2'd1, 1, 0, 0, 8'd2, 0);
    hold(4);
    din = 4'd4; ex(cyc + 2, 2'd2, 1, 0, 0, 8'd2, 0); hold(4);
    din = 4'd8; ex(cyc + 2, 2'd3, 1, 0, 0, 8'd2, 0); hold(4);
    din = 4'd4; ex(cyc + 2, 2'd2, 0, 0, 0, 8'd2, 0); hold(4);
    din = 4'd2; t0 = cyc; ex(cyc + 2, 2'd1, 0, 1, 0, 8'd2, 0);

    ex(t0 + 16, 2'd1, 0, 1, 0, 8'd2, 0);
    ex(t0 + 17, 2'd1, 0, !STALL_EN, 0, 8'd2, STALL_EN);
    hold(t0 + 20 - cyc);
    din = 4'd1;
    ex(cyc + 1, 2'd1, 0, !STALL_EN, 0, 8'd2, STALL_EN);
    ex(cyc + 2, 2'd0, 0, !STALL_EN, 0, 8'd2, 0);
    hold(3);

    din = 4'd2; ex(cyc + 2, 2'd1, 1, !STALL_EN, 0, 8'd2, 0); hold(3);
    din = 4'd4; ex(cyc + 2, 2'd2, 1, !STALL_EN, 0, 8'd2, 0); hold(3);
    din = 4'd8; ex(cyc + 2, 2'd3, 1, 1, 0, 8'd2, 0); hold(3);
    din = 4'd4; ex(cyc + 2, 2'd2, 0, 1, 0, 8'd2, 0); hold(3);

    reset_n = 1'b0;
    din = 4'd0;
    ex(cyc + 1, 2'd0, 0, 0, 0, 8'd0, 0);
    hold(1);
    reset_n = 1'b1;
    ex(cyc + 1, 2'd0, 0, 0, 0, 8'd0, 0);
    din = 4'd1; ex(cyc + 2, 2'd0, 0, 0, 0, 8'd0, 0); hold(3);
    din = 4'd2; ex(cyc + 2, 2'd1, 1, 0, 0, 8'd0, 0); hold(3);
    din = 4'd4; ex(cyc + 2, 2'd2, 1, 0, 0, 8'd0, 0); hold(3);
    din = 4'd8; ex(cyc + 2, 2'd3, 1, 1, 0, 8'd0, 0); hold(3);

    for (int i = 0; i < 300; i++) begin
      din = 4'd1; hold(2);
      din = 4'd2; hold(2);
      din = 4'd4; hold(2);
      din = 4'd8;
      ex(cyc + 2, 2'd3, 1, 1, 0, (i + 1 > 255) ? 8'd255 : 8'(i + 1), 0);
      hold(2);
    end

    din = 4'd1;
    ex(cyc + 2, 2'd0, 1, 0, 1, 8'd255, 0);
    hold(2);
    err_clr = 1'b1;
    ex(cyc + 1, 2'd0, 1, 0, 0, 8'd1, 0);
    hold(1);
    err_clr = 1'b0;
    hold(1);
    err_clr = 1'b1;
    ex(cyc + 1, 2'd0, 1, 0, 0, 8'd0, 0);
    hold(1);
    err_clr = 1'b0;

    for (int i = 0; i < 20 && q.size() > 0; i++) hold(1);
    if (q.size() > 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain %0d expectations left unchecked, need 0", q.size());
    end
    n_checks = n_checks + 1;
    if (n_ep != 303) begin
      n_fail = n_fail + 1;
      $display("FAIL err_pulse_total got %0d, need 303", n_ep);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cylon_checker.md
# cylon_checker

Receive-side monitor for the one-eye cylon LED pattern. Samples the 4-bit pattern driven to the front-panel LEDs and decodes the eye position and sweep direction. Verifies that each pattern change is the legal next step of the bounce sequence 1,2,4,8,4,2,1 (one-hot) and reports lock, errors and stalls. Used as a built-in self-check of the LED driver path and as a liveness indicator for the prescaled clock domain.

## Interface
Parameters:
- MXPRE, 21, generator prescaler width; the stall timeout is 2^(MXPRE+2)-1 cycles.
- LOCK_CNT, 3, consecutive legal steps required to declare lock (1..15).
- ERRW, 8, width of the saturating error counter.

Ports:
- clock  in  1  system clock; same clock as the pattern generator.
- reset_n  in  1  synchronous, active-low reset.
- din  in  4  LED pattern under test.
- err_clr  in  1  synchronous clear of err_cnt; a one-cycle pulse.
- pos  out  2  decoded eye index (0 = bit0 … 3 = bit3).
- dir  out  1  1 = sweeping toward bit3, 0 = toward bit0.
- locked  out  1  sequence tracked and valid.
- err_pulse  out  1  one-cycle pulse per sequence error while locked.
- err_cnt  out  ERRW  saturating count of err_pulse.
- stall  out  1  no pattern change within the timeout.

## Operation
- Input path: din_r <= din; din_p <= din_r. change = (din_r != din_p). onehot = din_r has exactly one bit set; idx = index of that bit.
- States: HUNT, SYNC, LOCK. Reset state is HUNT.
- HUNT:
  - On change with onehot: pos <= idx, goodcnt <= 0, go to SYNC.
  - Non-onehot changes are ignored.
- SYNC:
  - On change with onehot and idx == pos±1: dir <= (idx > pos), pos <= idx, goodcnt++.
  - When goodcnt reaches LOCK_CNT, go to LOCK and set locked.
  - On any other change: a onehot pattern reloads pos and clears goodcnt; otherwise go to HUNT. No error is counted in SYNC.
- LOCK, legal next step:
  - dir=1, pos<3: expect pos+1.
  - pos=3: expect 2 and set dir=0.
  - dir=0, pos>0: expect pos-1.
  - pos=0: expect 1 and set dir=1.
- LOCK, on a change that does not match the expected step:
  - Pulse err_pulse for one cycle, increment err_cnt, clear locked.
  - If onehot: pos <= idx, goodcnt <= 0, go to SYNC. Otherwise go to HUNT.
- A repeated pattern is not a change and is never an error. This covers the dwell at the 0→0 wrap of the generator.
- err_cnt saturates at all-ones. If err_clr and err_pulse occur in the same cycle, err_cnt <= 1.
- Stall timer:
  - Counts cycles since the last change; cleared on change.
  - When the timer reaches 2^(MXPRE+2)-1: set stall, clear locked, go to HUNT, hold the timer saturated.
  - stall clears on the next change.
  - If a change and timer saturation occur in the same cycle, the change wins (no stall).

## Timing
- Reset values: pos=0, dir=0, locked=0, err_pulse=0, err_cnt=0, stall=0; din_r and din_p = 0; state HUNT.
- Latency: a din change sampled at edge E is decoded at edge E+1. pos, dir, locked, err_pulse and stall are registered and valid after E+1.
- err_pulse is never high for more than one cycle per change.
- reset_n low mid-sequence restores all reset values on the next edge. Re-lock then needs 1 + LOCK_CNT legal changes.

## Configuration
- CYLON_CHECK_STALL_EN defined: the stall timer and the stall output behave as above.
- Not defined: no timer is synthesized, stall is tied 0, and the block never leaves LOCK by timeout.

## Structure
- cylon_pkg: state enum (HUNT/SYNC/LOCK), the legal pattern constants, and the next-step function (pos, dir → expected idx, new dir).
- One sub-module: onehot4_dec (din_r → idx[1:0], onehot), combinational.
- The FSM, counters and timer live in cylon_checker.

## Test plan
Use MXPRE=2 (timeout 15 cycles), LOCK_CNT=3 and ERRW=8 unless noted.
- Legal sweep: drive 1,2,4,8,4,2,1,1,2 with each held 4 cycles. locked rises 2 cycles after the 4th change; pos and dir then track; err_cnt stays 0.
- Skip: while locked at pos=1 dir=1, drive 8. err_pulse is high for exactly 1 cycle, err_cnt=1, locked=0, state SYNC with pos=3.
- Invalid pattern: while locked, drive 4'b0110. err_cnt increments, state HUNT, pos unchanged. The next onehot change enters SYNC.
- Stall (macro on): hold din constant 15 cycles after lock. stall=1 and locked=0. One change clears stall and enters SYNC. With the macro off, stall stays 0.
- Saturation/clear: force 300 errors with ERRW=8. err_cnt=255. Assert err_clr together with an error: err_cnt=1.
- Reset mid-lock: pulse reset_n low 1 cycle while locked at pos=2. All outputs are 0 on the next edge, and re-lock requires 4 legal changes.
